// File: rtl/ahb_lite_sram_slave_if.sv
// ahb_lite_sram_slave_if: AHB-lite bus bundle between a master/interconnect and the SRAM responder.
interface ahb_lite_sram_slave_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic                  Hsel;
  logic                  Hready;
  logic                  Hwrite;
  logic [1:0]            Htrans;
  logic [2:0]            Hsize;
  logic [2:0]            Hburst;
  logic [ADDR_WIDTH-1:0] Haddr;
  logic [DATA_WIDTH-1:0] Hwdata;
  logic [DATA_WIDTH-1:0] Hrdata;
  logic                  Hreadyout;
  logic                  Hresp;
  modport master(output Hsel, Hready, Hwrite, Htrans, Hsize, Hburst, Haddr, Hwdata,
                 input Hrdata, Hreadyout, Hresp);
  modport slave(input Hsel, Hready, Hwrite, Htrans, Hsize, Hburst, Haddr, Hwdata,
                output Hrdata, Hreadyout, Hresp);
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: word-organised AHB-lite SRAM responder with WAIT_STATES wait cycles per data phase.
// Define AHB_SLV_ERR_EN to answer out-of-range, misaligned or oversized transfers with a two-cycle ERROR.
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic                  Hclk,
  input logic                  HRESET,
  ahb_lite_sram_slave_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;
  logic [2:0]               state;
  logic [3:0]               cnt;
  logic                     wr;
  logic [IW-1:0]            idx;
  logic [NB-1:0]            be, be_n;
  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];
  logic                     hro, acc, err;
  logic [2:0]               sz;
  logic [LB-1:0]            lmask, off;
  logic [ADDR_WIDTH-LB-1:0] word;
  logic                     unused_ok;
  assign hro   = state != S_WAIT && state != S_ERR1;
  assign acc   = bus.Hsel & bus.Hready & bus.Htrans[1] & hro;
  assign sz    = bus.Hsize > 3'(LB) ? 3'(LB) : bus.Hsize;
  assign lmask = LB'((1 << sz) - 1);
  assign off   = bus.Haddr[LB-1:0] & ~lmask;
  assign word  = bus.Haddr[ADDR_WIDTH-1:LB];
  assign unused_ok = ^{bus.Hburst, bus.Htrans[0]};
`ifdef AHB_SLV_ERR_EN
  assign err = (word >= (ADDR_WIDTH-LB)'(MEM_DEPTH)) | (|(bus.Haddr[LB-1:0] & lmask)) | (bus.Hsize > 3'(LB));
  assign bus.Hresp = state == S_ERR1 || state == S_ERR2;
`else
  assign err = 1'b0;
  assign bus.Hresp = 1'b0;
`endif
  assign bus.Hreadyout = hro;
  assign bus.Hrdata    = (state == S_DATA && !wr) ? mem[idx] : '0;
  // little-endian lanes: 2^sz bytes starting at the (aligned) lane offset
  always_comb begin
    be_n = '0;
    for (int i = 0; i < NB; i++) be_n[i] = (i >= int'(off)) && (i < int'(off) + (1 << sz));
  end
  always_ff @(posedge Hclk) begin
    if (HRESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      wr    <= 1'b0;
      idx   <= '0;
      be    <= '0;
    end else if (state == S_WAIT) begin
      state <= cnt == 4'd1 ? S_DATA : S_WAIT;
      cnt   <= cnt - 4'd1;
    end else if (state == S_ERR1) begin
      state <= S_ERR2;
    end else if (acc) begin
      state <= err ? S_ERR1 : (WAIT_STATES > 0 ? S_WAIT : S_DATA);
      cnt   <= 4'(WAIT_STATES);
      wr    <= bus.Hwrite;
      idx   <= IW'(word % (ADDR_WIDTH-LB)'(MEM_DEPTH));
      be    <= be_n;
    end else begin
      state <= S_IDLE;
    end
  end
  always_ff @(posedge Hclk) begin
    if (!HRESET && state == S_DATA && wr)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[idx][8*i +: 8] <= bus.Hwdata[8*i +: 8];
  end
endmodule
